// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryptor. The key is expanded forward one round key per clock,
// then the ten inverse rounds run one per clock. The plaintext is held on a valid/ready output.
module inv_cipher_iter #(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:Nk*32-1] in,
   input  logic [0:Nk*32-1] key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:Nk*32-1] out
);

   localparam int unsigned W  = Nk * 32;
   localparam int unsigned CW = 4;
   localparam logic [7:0] INV_EXP = 8'd254;

   generate
      if (Nk != 4) begin : g_bad_nk
         $error("inv_cipher_iter: only Nk=4 is supported");
      end
      if (Nr != 10) begin : g_bad_nr
         $error("inv_cipher_iter: only Nr=10 is supported");
      end
   endgenerate

   // GF(2^8) multiply, reduction polynomial 0x11b
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 7; k >= 0; k--) begin
         r = gf_mul(r, r);
         if (INV_EXP[k]) r = gf_mul(r, x);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      logic [7:0] v;
      v = a;
      for (int unsigned k = 0; k < n; k++) v = {v[6:0], v[7]};
      return v;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [CW-1:0] i);
      logic [7:0] c;
      c = 8'h00;
      case (i)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Column byte 0 sits in the most significant byte
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_KEYEXP = 2'd1,
      S_ROUND  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [0:W-1]    r_ct;
   logic [0:W-1]    r_s;
   logic [0:W-1]    r_out;
   logic [0:W-1]    r_rk [0:Nr];
   logic            r_out_valid;

   logic            w_idle;
   logic            w_accept;
   logic            w_out_hs;
   logic [0:W-1]    w_prev_rk;
   logic [0:W-1]    w_next_rk;
   logic [0:W-1]    w_cur_rk;
   logic [0:W-1]    w_sub;
   logic [0:W-1]    w_ark;
   logic [0:W-1]    w_imc;
   logic [0:W-1]    w_round;
   logic [0:31]     w_rot;
   logic [0:31]     w_subw;
   logic [0:31]     w_temp;
   logic [0:31]     w_k0, w_k1, w_k2, w_k3;

   // Forward key expansion of the previous round key
   assign w_prev_rk = r_rk[r_cnt - CW'(1)];
   assign w_rot     = {w_prev_rk[104:111], w_prev_rk[112:119],
                       w_prev_rk[120:127], w_prev_rk[96:103]};

   generate
      for (genvar j = 0; j < 4; j++) begin : g_subw
         assign w_subw[j*8 +: 8] = sbox(w_rot[j*8 +: 8]);
      end
   endgenerate

   assign w_temp    = w_subw ^ {rcon(r_cnt), 24'h000000};
   assign w_k0      = w_prev_rk[0:31]   ^ w_temp;
   assign w_k1      = w_prev_rk[32:63]  ^ w_k0;
   assign w_k2      = w_prev_rk[64:95]  ^ w_k1;
   assign w_k3      = w_prev_rk[96:127] ^ w_k2;
   assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};

   // Inverse round: InvShiftRows folded into the InvSubBytes source index
   generate
      for (genvar c = 0; c < 4; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned SRC = 4 * ((c + 4 - r) % 4) + r;
            assign w_sub[(4*c+r)*8 +: 8] = inv_sbox(r_s[SRC*8 +: 8]);
         end
         assign w_imc[c*32 +: 32] = inv_mix_col(w_ark[c*32 +: 32]);
      end
   endgenerate

   assign w_cur_rk = r_rk[r_cnt];
   assign w_ark    = w_sub ^ w_cur_rk;
   assign w_round  = (r_cnt != '0) ? w_imc : w_ark;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)               w_state_nxt = S_KEYEXP;
         S_KEYEXP: if (r_cnt == CW'(Nr))       w_state_nxt = S_ROUND;
         S_ROUND:  if (r_cnt == '0)            w_state_nxt = S_DONE;
         S_DONE:   if (w_out_hs)               w_state_nxt = S_IDLE;
         default:                              w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_idle   = (r_state == S_IDLE);
      w_accept = in_valid && w_idle;
      w_out_hs = (r_state == S_DONE) && r_out_valid && out_ready;
      in_ready = w_idle;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_ct        <= '0;
         r_s         <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_rk        <= '{default: '0};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ct     <= in;
                  r_rk[0]  <= key;
                  r_cnt    <= CW'(1);
               end
            end
            S_KEYEXP: begin
               r_rk[r_cnt] <= w_next_rk;
               if (r_cnt == CW'(Nr)) begin
                  r_s   <= r_ct ^ w_next_rk;
                  r_cnt <= CW'(Nr - 1);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ROUND: begin
               r_s <= w_round;
               if (r_cnt == '0) begin
                  r_out       <= w_round;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               if (w_out_hs) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench for inv_cipher_iter: FIPS-197 vectors, latency, backpressure,
// input isolation, mid-job reset and back-to-back jobs.
module tb_inv_cipher_iter;

   localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] ZK_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [0:127] tb_in     = '0;
   logic [0:127] tb_key    = '0;
   logic         in_ready;
   logic         out_valid;
   logic [0:127] tb_out;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   inv_cipher_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (tb_in),
      .key       (tb_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (tb_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Present a job at a falling edge once in_ready is seen; returns the accept-edge cycle
   task automatic start_job(input logic [0:127] ct, input logic [0:127] k, output int acc_cyc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      tb_in    = ct;
      tb_key   = k;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic wait_out(output int ov_cyc);
      int guard;
      guard = 0;
      while (!out_valid && guard < 40) begin
         @(posedge clk);
         #1;
         guard++;
      end
      ov_cyc = cyc;
   endtask

   task automatic run_job(input string tag, input logic [0:127] ct, input logic [0:127] k,
                          input logic [0:127] exp);
      int a;
      int o;
      start_job(ct, k, a);
      wait_out(o);
      check({tag, "_latency"}, 128'(o - a), 128'd20);
      check({tag, "_valid"}, 128'(out_valid), 128'd1);
      check({tag, "_out"}, tb_out, exp);
   endtask

   task automatic check_abort(input string tag);
      int seen;
      rst_n = 1'b0;
      #1;
      check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      check({tag, "_out"}, tb_out, 128'd0);
      check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      check({tag, "_no_late_valid"}, 128'(seen), 128'd0);
   endtask

   initial begin
      int a1, o1, a2, o2, a, o;

      #12;
      check("reset_in_ready", 128'(in_ready), 128'd1);
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_out", tb_out, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // C.1 followed immediately by the zero-key job with out_ready held high
      start_job(C1_CT, C1_KEY, a1);
      wait_out(o1);
      check("c1_latency", 128'(o1 - a1), 128'd20);
      check("c1_out", tb_out, C1_PT);
      start_job(ZK_CT, 128'd0, a2);
      check("b2b_accept_gap", 128'(a2 - o1), 128'd2);
      wait_out(o2);
      check("zero_latency", 128'(o2 - a2), 128'd20);
      check("zero_out", tb_out, 128'd0);

      run_job("fips_b", B_CT, B_KEY, B_PT);

      // Backpressure: output held, no new accept
      start_job(B_CT, B_KEY, a);
      out_ready = 1'b0;
      wait_out(o);
      check("bp_latency", 128'(o - a), 128'd20);
      for (int k = 1; k <= 15; k++) begin
         if (k == 5) begin
            tb_in    = C1_CT;
            tb_key   = C1_KEY;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("bp_out_valid", 128'(out_valid), 128'd1);
         check("bp_out", tb_out, B_PT);
         check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 128'(out_valid), 128'd0);
      check("bp_release_in_ready", 128'(in_ready), 128'd1);
      check("bp_release_out_held", tb_out, B_PT);

      // Input isolation: inputs scrambled right after accept
      start_job(C1_CT, C1_KEY, a);
      tb_in  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      tb_key = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
      wait_out(o);
      check("iso_latency", 128'(o - a), 128'd20);
      check("iso_out", tb_out, C1_PT);

      // Reset during key expansion (between edges E6 and E7)
      start_job(C1_CT, C1_KEY, a);
      repeat (6) @(posedge clk);
      #1;
      check_abort("rst_keyexp");
      run_job("after_rst_keyexp", C1_CT, C1_KEY, C1_PT);

      // Reset during the fifth inverse round (between edges E14 and E15)
      start_job(B_CT, B_KEY, a);
      repeat (14) @(posedge clk);
      #1;
      check_abort("rst_round");
      run_job("after_rst_round", C1_CT, C1_KEY, C1_PT);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
